alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: W, 8, datapath and register width.
REQ-002 Parameter: Ops, 4, ALU opcode width.
REQ-003 Clk  in  1  the block's one clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset: asserted at 0, takes effect immediately, released synchronously to Clk.
REQ-005 Start  in  1  begin program execution from PC=0.
REQ-006 InitWe  in  1  register-file preload write enable, honoured only in IDLE and DONE.
REQ-007 InitAddr  in  2  preload register index.
REQ-008 InitData  in  W  preload data.
REQ-009 Instr  in  9  instruction word from instruction memory.
REQ-010 InstrValid  in  1  Instr is valid.
REQ-011 InstrReady  out  1  sequencer accepts Instr this cycle.
REQ-012 PC  out  8  address of the instruction being fetched.
REQ-013 AluOp  out  Ops  opcode driven to the external combinational ALU.
REQ-014 AluA, AluB  out  W each  ALU operands.
REQ-015 AluOut  in  W  ALU result, same cycle.
REQ-016 AluZero  in  1  ALU zero flag, ignored except for waveform checks.
REQ-017 Result  out  W  current content of R0.
REQ-018 Done  out  1  program halted.

Function
REQ-019 Four 8-bit registers R0..R3; instruction fields: op=Instr[8:5], rd=Instr[4:3], rs=Instr[2:1], Instr[0] ignored.
REQ-020 Opcodes: ADD=0, LSH=1, RSH=2, AND=3, OR=4, NEG=5, GEQ=6, EQ=7, NEQ=8, BNZ=9, HALT=F; A..E are NOPs (no register write, PC+1).
REQ-021 FSM states: IDLE, FETCH, EXEC, WB, DONE; reset state IDLE.
REQ-022 IDLE: Start=1 -> PC<=0, go FETCH; otherwise InitWe=1 writes R[InitAddr]<=InitData.
REQ-023 FETCH: InstrReady=1; on InstrValid=1, latch Instr into IR, go EXEC; InstrValid=0 holds FETCH, PC stable.
REQ-024 InstrReady SHALL be 0 in all states other than FETCH.
REQ-025 EXEC: AluOp=IR.op, AluA=R[rd], AluB=R[rs]; AluOut captured into result register; HALT -> DONE, else go WB.
REQ-026 AluOp, AluA, AluB SHALL be 0 outside EXEC.
REQ-027 WB: ops 0..8 write R[rd]<=captured result; PC<=PC+1, go FETCH.
REQ-028 BNZ: no register write; if R[rd]!=0 (sampled in EXEC) PC<=R[rs], else PC<=PC+1.
REQ-029 PC increment wraps modulo 256 (255 -> 0).
REQ-030 Throughput: 3 cycles per instruction with InstrValid held high (FETCH, EXEC, WB).
REQ-031 DONE: Done=1, PC held; Start=1 -> PC<=0, Done<=0, go FETCH; registers retained.
REQ-032 Start ignored in FETCH, EXEC, WB; InitWe ignored outside IDLE/DONE.
REQ-033 Same-register source and destination (rd=rs) SHALL use the pre-write value.

Reset
REQ-034 Reset=0 at any time: state<=IDLE, PC, IR, R0..R3, result register <=0; Done=0, InstrReady=0, AluOp/AluA/AluB=0.
REQ-035 Reset asserted mid-instruction aborts it; no register write or PC update completes.

Verification
REQ-036 Preload R1=5, R2=7; program ADD rd=1 rs=2, HALT -> R1=12, Done=1 after 5 accepted-fetch-driven cycles, AluOp=0 seen in EXEC.
REQ-037 R3=0x81, RSH R3,R3 then LSH R3,R3 -> R3=0x40 then 0x80; R0 via NEG of 1 -> Result=0xFF.
REQ-038 BNZ rd=1(R1=3) rs=2(R2=0x10) -> PC=0x10; repeat with R1=0 -> PC=prior PC+1.
REQ-039 InstrValid low for 4 cycles in FETCH -> InstrReady stays 1, PC unchanged, state stays FETCH, no writes.
REQ-040 Reset pulsed low during WB of ADD -> target register 0, PC=0, state IDLE; Start re-runs program correctly.
REQ-041 BNZ to 0xFF with NOP at 0xFF -> next PC=0x00; HALT then Start -> Done drops, fetch restarts at PC=0 with registers intact.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: a multi-cycle sequencer for a small 4-register machine.
// It fetches 9-bit instructions from an external memory, drives an external
// combinational ALU in EXEC, and writes the ALU result back in WB.
// The BNZ branch and HALT are resolved inside the sequencer.
//
// Ports
//   Clk, Reset       clock; asynchronous active-low reset
//   Start            run the program from PC=0 (honoured in IDLE/DONE only)
//   InitWe/Addr/Data register-file preload (honoured in IDLE/DONE only)
//   Instr/InstrValid instruction word from instruction memory and its valid
//   InstrReady       high in FETCH; the instruction is taken when InstrValid is high
//   PC               fetch address
//   AluOp/AluA/AluB  operands to the external ALU; zero outside EXEC
//   AluOut/AluZero   ALU result (same cycle); AluZero is not used
//   Result           contents of R0
//   Done             program has halted
module alu_seq #(
  parameter int unsigned W   = 8,
  parameter int unsigned Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           InitWe,
  input  logic [1:0]     InitAddr,
  input  logic [W-1:0]   InitData,
  input  logic [8:0]     Instr,
  input  logic           InstrValid,
  output logic           InstrReady,
  output logic [7:0]     PC,
  output logic [Ops-1:0] AluOp,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  input  logic [W-1:0]   AluOut,
  input  logic           AluZero,
  output logic [W-1:0]   Result,
  output logic           Done
);

  localparam int unsigned PC_W = 8;
  localparam int unsigned IW   = 9;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RA_W = 2;
  localparam int unsigned NREG = 4;

  localparam logic [OPW-1:0] OP_NEQ  = 4'h8;
  localparam logic [OPW-1:0] OP_BNZ  = 4'h9;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    rf_q [NREG];
  logic [W-1:0]    rf_d [NREG];
  logic            br_taken_q, br_taken_d;
  logic [PC_W-1:0] br_tgt_q, br_tgt_d;
  logic            instr_ready_q, instr_ready_d;
  logic            done_q, done_d;
  logic [Ops-1:0]  alu_op_q, alu_op_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;

  // Fields of the latched instruction and of the incoming instruction word
  logic [OPW-1:0]  ir_op, in_op;
  logic [RA_W-1:0] ir_rd, ir_rs, in_rd, in_rs;

  assign ir_op = ir_q[8:5];
  assign ir_rd = ir_q[4:3];
  assign ir_rs = ir_q[2:1];
  assign in_op = Instr[8:5];
  assign in_rd = Instr[4:3];
  assign in_rs = Instr[2:1];

  // Instruction bit 0 and the ALU zero flag carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{AluZero, ir_q[0]};

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    res_d         = res_q;
    rf_d          = rf_q;
    br_taken_d    = br_taken_q;
    br_tgt_d      = br_tgt_q;
    instr_ready_d = 1'b0;
    done_d        = 1'b0;
    alu_op_d      = '0;
    alu_a_d       = '0;
    alu_b_d       = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end else if (InitWe) begin
          rf_d[InitAddr] = InitData;
        end
      end

      S_FETCH: begin
        if (InstrValid) begin
          ir_d    = Instr;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        // Branch condition and target are sampled here, before any write
        res_d      = AluOut;
        br_taken_d = (rf_q[ir_rd] != '0);
        br_tgt_d   = PC_W'(rf_q[ir_rs]);
        state_d    = (ir_op == OP_HALT) ? S_DONE : S_WB;
      end

      S_WB: begin
        if (ir_op <= OP_NEQ) begin
          rf_d[ir_rd] = res_q;
        end
        if ((ir_op == OP_BNZ) && br_taken_q) begin
          pc_d = br_tgt_q;
        end else begin
          pc_d = PC_W'(pc_q + 1'b1);
        end
        state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    // EXEC is entered only on an accepted fetch, so Instr holds the operands
    // and the register file cannot change before EXEC.
    instr_ready_d = (state_d == S_FETCH);
    done_d        = (state_d == S_DONE);
    if (state_d == S_EXEC) begin
      alu_op_d = Ops'(in_op);
      alu_a_d  = rf_q[in_rd];
      alu_b_d  = rf_q[in_rs];
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      res_q         <= '0;
      rf_q          <= '{default: '0};
      br_taken_q    <= 1'b0;
      br_tgt_q      <= '0;
      instr_ready_q <= 1'b0;
      done_q        <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      res_q         <= res_d;
      rf_q          <= rf_d;
      br_taken_q    <= br_taken_d;
      br_tgt_q      <= br_tgt_d;
      instr_ready_q <= instr_ready_d;
      done_q        <= done_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
    end
  end

  assign InstrReady = instr_ready_q;
  assign PC         = pc_q;
  assign AluOp      = alu_op_q;
  assign AluA       = alu_a_q;
  assign AluB       = alu_b_q;
  assign Result     = rf_q[0];
  assign Done       = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an instruction-level reference model plus directed programs.
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'h0, LSH = 4'h1, RSH = 4'h2, AND_ = 4'h3, OR_ = 4'h4;
  localparam logic [3:0] NEG = 4'h5, GEQ = 4'h6, EQ = 4'h7, NEQ = 4'h8, BNZ = 4'h9;
  localparam logic [3:0] NOPA = 4'hA, NOPB = 4'hB, NOPC = 4'hC, HALT = 4'hF;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       InitWe;
  logic [1:0] InitAddr;
  logic [7:0] InitData;
  logic [8:0] Instr;
  logic       InstrValid;
  logic       InstrReady;
  logic [7:0] PC;
  logic [3:0] AluOp;
  logic [7:0] AluA;
  logic [7:0] AluB;
  logic [7:0] AluOut;
  logic       AluZero;
  logic [7:0] Result;
  logic       Done;

  alu_seq #(.W(8), .Ops(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InitWe(InitWe), .InitAddr(InitAddr),
    .InitData(InitData), .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .PC(PC), .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluOut(AluOut),
    .AluZero(AluZero), .Result(Result), .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // External ALU: shifts are by one place, NEG is two's complement of A
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      ADD:     return 8'(a + b);
      LSH:     return 8'(a << 1);
      RSH:     return a >> 1;
      AND_:    return a & b;
      OR_:     return a | b;
      NEG:     return 8'(8'h00 - a);
      GEQ:     return {7'h0, (a >= b)};
      EQ:      return {7'h0, (a == b)};
      NEQ:     return {7'h0, (a != b)};
      default: return 8'h00;
    endcase
  endfunction

  always_comb AluOut = alu_f(AluOp, AluA, AluB);
  assign AluZero = (AluOut == 8'h00);

  function automatic logic [8:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs);
    return {op, rd, rs, 1'b0};
  endfunction

  // Instruction memory answers the current PC
  logic [8:0] imem [256];
  initial forever begin
    @(negedge Clk);
    Instr = imem[PC];
  end

  // Reference model: each instruction is executed whole when it is accepted;
  // its effect becomes visible at the end of WB (or the machine halts after EXEC).
  typedef enum logic [2:0] {M_IDLE, M_FETCH, M_EXEC, M_WB, M_DONE} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] m_r [4] = '{default: 8'h00};
  logic [7:0] p_r [4] = '{default: 8'h00};
  logic [7:0] m_pc = 8'h00, p_pc = 8'h00;
  logic       p_halt = 1'b0;
  logic       e_ready = 1'b0, e_done = 1'b0;
  logic [7:0] e_pc = 8'h00, e_r0 = 8'h00, e_a = 8'h00, e_b = 8'h00;
  logic [3:0] e_op = 4'h0;
  logic [8:0] t_ins;
  logic [3:0] t_op;
  logic [1:0] t_rd, t_rs;
  logic [7:0] t_a, t_b, t_npc;
  logic [7:0] t_nr [4];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode <= M_IDLE; m_pc <= 8'h00; m_r <= '{default: 8'h00}; p_halt <= 1'b0;
      e_ready <= 1'b0; e_done <= 1'b0; e_pc <= 8'h00; e_r0 <= 8'h00;
      e_op <= 4'h0; e_a <= 8'h00; e_b <= 8'h00;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (Start) begin
            m_mode <= M_FETCH; m_pc <= 8'h00; e_pc <= 8'h00; e_ready <= 1'b1; e_done <= 1'b0;
          end else if (InitWe) begin
            m_r[InitAddr] <= InitData;
            if (InitAddr == 2'd0) e_r0 <= InitData;
          end
        end
        M_FETCH: begin
          if (InstrValid) begin
            t_ins = imem[m_pc];
            t_op = t_ins[8:5]; t_rd = t_ins[4:3]; t_rs = t_ins[2:1];
            t_a = m_r[t_rd]; t_b = m_r[t_rs];
            t_nr = m_r;
            t_npc = 8'(m_pc + 8'd1);
            if (t_op <= NEQ) t_nr[t_rd] = alu_f(t_op, t_a, t_b);
            if (t_op == BNZ && t_a != 8'h00) t_npc = t_b;
            p_r <= t_nr; p_pc <= t_npc; p_halt <= (t_op == HALT);
            e_op <= t_op; e_a <= t_a; e_b <= t_b; e_ready <= 1'b0;
            m_mode <= M_EXEC;
          end
        end
        M_EXEC: begin
          e_op <= 4'h0; e_a <= 8'h00; e_b <= 8'h00;
          if (p_halt) begin
            m_mode <= M_DONE; e_done <= 1'b1;
          end else begin
            m_mode <= M_WB;
          end
        end
        default: begin
          m_r <= p_r; m_pc <= p_pc; e_pc <= p_pc; e_r0 <= p_r[0];
          e_ready <= 1'b1; m_mode <= M_FETCH;
        end
      endcase
    end
  end

  // Compare every output against the model each cycle
  always @(negedge Clk) begin
    if (chk_en) begin
      check("InstrReady", 16'(InstrReady), 16'(e_ready));
      check("Done", 16'(Done), 16'(e_done));
      check("PC", 16'(PC), 16'(e_pc));
      check("Result", 16'(Result), 16'(e_r0));
      check("AluOp", 16'(AluOp), 16'(e_op));
      check("AluA", 16'(AluA), 16'(e_a));
      check("AluB", 16'(AluB), 16'(e_b));
    end
  end

  task automatic preload(input logic [1:0] addr, input logic [7:0] data);
    InitWe = 1'b1; InitAddr = addr; InitData = data;
    @(negedge Clk);
    InitWe = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while (Done !== 1'b1 && k < max) begin
      @(negedge Clk);
      k++;
    end
    check("wait_done", 16'(Done), 16'h1);
  endtask

  task automatic wait_pc(input logic [7:0] pc, input int max);
    int k;
    k = 0;
    while (PC !== pc && k < max) begin
      @(negedge Clk);
      k++;
    end
    check("wait_pc", 16'(PC), 16'(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; InitWe = 1'b0; InitAddr = 2'd0; InitData = 8'h00;
    InstrValid = 1'b1; Instr = 9'h000;
    for (int i = 0; i < 256; i++) imem[i] = enc(HALT, 2'd0, 2'd0);
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    check("rst_ready", 16'(InstrReady), 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    check("rst_pc", 16'(PC), 16'h0);
    check("rst_result", 16'(Result), 16'h0);
    check("rst_aluop", 16'(AluOp), 16'h0);
    Reset = 1'b1;
    @(negedge Clk);

    // ADD R1,R2 then HALT: Done five cycles after entering FETCH
    preload(2'd1, 8'h05); preload(2'd2, 8'h07);
    imem[0] = enc(ADD, 2'd1, 2'd2); imem[1] = enc(HALT, 2'd1, 2'd0);
    pulse_start();
    @(negedge Clk);
    check("add_aluop", 16'(AluOp), 16'h0);
    check("add_alua", 16'(AluA), 16'h5);
    check("add_alub", 16'(AluB), 16'h7);
    repeat (3) @(negedge Clk);
    check("halt_r1", 16'(AluA), 16'hC);
    check("done_early", 16'(Done), 16'h0);
    @(negedge Clk);
    check("done_5cyc", 16'(Done), 16'h1);
    check("halt_pc", 16'(PC), 16'h1);

    // Shifts on R3 and NEG of 1 into R0
    preload(2'd3, 8'h81); preload(2'd0, 8'h01);
    imem[0] = enc(RSH, 2'd3, 2'd3); imem[1] = enc(LSH, 2'd3, 2'd3);
    imem[2] = enc(NEG, 2'd0, 2'd0); imem[3] = enc(HALT, 2'd3, 2'd0);
    pulse_start();
    @(negedge Clk);
    check("rsh_in", 16'(AluA), 16'h81);
    repeat (3) @(negedge Clk);
    check("lsh_in", 16'(AluA), 16'h40);
    repeat (6) @(negedge Clk);
    check("r3_final", 16'(AluA), 16'h80);
    wait_done(5);
    check("neg_result", 16'(Result), 16'hFF);

    // Logic/compare ops, a NOP, and rd=rs reading the pre-write value
    preload(2'd0, 8'h3C); preload(2'd1, 8'h0F); preload(2'd2, 8'h3C);
    imem[0] = enc(AND_, 2'd0, 2'd1); imem[1] = enc(OR_, 2'd0, 2'd2);
    imem[2] = enc(EQ, 2'd0, 2'd2);   imem[3] = enc(GEQ, 2'd0, 2'd1);
    imem[4] = enc(NEQ, 2'd0, 2'd1);  imem[5] = enc(NOPC, 2'd0, 2'd0);
    imem[6] = enc(ADD, 2'd0, 2'd0);  imem[7] = enc(HALT, 2'd0, 2'd0);
    pulse_start();
    wait_done(40);
    check("mix_result", 16'(Result), 16'h2);

    // BNZ taken and not taken
    preload(2'd1, 8'h03); preload(2'd2, 8'h10);
    imem[0] = enc(NOPA, 2'd0, 2'd0); imem[1] = enc(BNZ, 2'd1, 2'd2);
    imem[2] = enc(HALT, 2'd0, 2'd0); imem[16] = enc(HALT, 2'd0, 2'd0);
    pulse_start();
    wait_done(20);
    check("bnz_taken_pc", 16'(PC), 16'h10);
    preload(2'd1, 8'h00);
    pulse_start();
    wait_done(20);
    check("bnz_fall_pc", 16'(PC), 16'h2);

    // Fetch stall with stray Start/InitWe that must be ignored
    preload(2'd0, 8'h01); preload(2'd1, 8'h02);
    imem[0] = enc(ADD, 2'd0, 2'd1); imem[1] = enc(HALT, 2'd0, 2'd0);
    InstrValid = 1'b0;
    pulse_start();
    Start = 1'b1; InitWe = 1'b1; InitAddr = 2'd0; InitData = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Start = 1'b0; InitWe = 1'b0;
      check("stall_ready", 16'(InstrReady), 16'h1);
      check("stall_pc", 16'(PC), 16'h0);
      check("stall_r0", 16'(Result), 16'h1);
    end
    InstrValid = 1'b1;
    wait_done(20);
    check("stall_result", 16'(Result), 16'h3);

    // Reset during WB of ADD R0,R1, then re-run
    preload(2'd0, 8'h02); preload(2'd1, 8'h03);
    pulse_start();
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    check("wbrst_result", 16'(Result), 16'h0);
    check("wbrst_pc", 16'(PC), 16'h0);
    check("wbrst_ready", 16'(InstrReady), 16'h0);
    check("wbrst_done", 16'(Done), 16'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("postrst_result", 16'(Result), 16'h0);
    preload(2'd0, 8'h02); preload(2'd1, 8'h03);
    pulse_start();
    wait_done(20);
    check("rerun_result", 16'(Result), 16'h5);

    // BNZ to 0xFF, NOP there wraps PC to 0, HALT, then restart
    preload(2'd1, 8'h01); preload(2'd2, 8'hFF);
    imem[0] = enc(BNZ, 2'd1, 2'd2); imem[255] = enc(NOPB, 2'd0, 2'd0);
    pulse_start();
    wait_pc(8'hFF, 20);
    imem[0] = enc(HALT, 2'd2, 2'd0);
    wait_pc(8'h00, 10);
    @(negedge Clk);
    check("wrap_halt_op", 16'(AluOp), 16'hF);
    check("wrap_halt_r2", 16'(AluA), 16'hFF);
    @(negedge Clk);
    check("wrap_done", 16'(Done), 16'h1);
    check("wrap_pc", 16'(PC), 16'h0);
    check("wrap_r0", 16'(Result), 16'h5);
    pulse_start();
    check("restart_done", 16'(Done), 16'h0);
    check("restart_ready", 16'(InstrReady), 16'h1);
    check("restart_pc", 16'(PC), 16'h0);
    wait_done(10);
    check("restart_r0", 16'(Result), 16'h5);

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
